// File: rtl/usb_tx_encoder_if.sv
// Byte handshake between the packet controller and the USB transmitter.
// Latency: none (wires only).
// Backpressure: tx_ready low stalls the producer; tx_data/tx_last are only sampled with tx_valid && tx_ready.
//
// Signals:
//   tx_data  [7:0]  packet byte
//   tx_valid        tx_data valid
//   tx_last         tx_data is the final byte of the packet
//   tx_ready        transmitter holding register is empty
interface usb_tx_encoder_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// Full-speed USB bit transmitter: SYNC, bit-stuffed NRZI data (LSB first), EOP onto D+/D-.
// Latency: first K one cycle after the holding register fills; each symbol lasts CLKS_PER_BIT cycles.
// Backpressure: tx_ready = holding register empty; a byte waits there until its byte boundary.
//
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   tx_if (slave)           tx_data/tx_valid/tx_last in, tx_ready out
//   d_plus, d_minus         registered line outputs (J=10, K=01, SE0=00)
//   tx_active               high from first SYNC symbol through the end of EOP
//   tx_done                 one-cycle pulse once EOP has completed
//   tx_error                one-cycle pulse when the holding register underruns mid-packet
// Build option: define USB_TX_CRC16_EN to append the complemented CRC16 after the last byte.
module usb_tx_encoder #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    usb_tx_encoder_if.slave  tx_if,
    output logic             d_plus,
    output logic             d_minus,
    output logic             tx_active,
    output logic             tx_done,
    output logic             tx_error
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    // SYNC is 8'h80 sent LSB first; bit 0 goes out on the IDLE->SYNC edge,
    // so the shift register starts with the remaining seven bits.
    localparam logic [7:0] SYNC_REST = 8'h40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_last_q, hold_last_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bits_left_q, bits_left_d;
    logic          cur_last_q, cur_last_d;
    logic [2:0]    ones_q, ones_d;
    logic [1:0]    line_q, line_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          eop_cnt_q, eop_cnt_d;

`ifdef USB_TX_CRC16_EN
    logic [15:0]   crc_q, crc_d;
    logic [1:0]    crc_sel_q, crc_sel_d;   // 0: none sent, 1: low byte sent, 2: both sent

    // Reflected CRC16 (x^16+x^15+x^2+1), data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction
`endif

    logic       wrap;
    logic       boundary;
    logic       load_byte;
    logic [7:0] byte_val;
    logic       take_hold;
    logic       send_bit;
    logic       bit_val;
    logic       count_ones;
    logic       go_eop;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        cur_last_d  = cur_last_q;
        ones_d      = ones_q;
        line_d      = line_q;
        active_d    = active_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        eop_cnt_d   = eop_cnt_q;
`ifdef USB_TX_CRC16_EN
        crc_d       = crc_q;
        crc_sel_d   = crc_sel_q;
`endif
        boundary    = 1'b0;
        load_byte   = 1'b0;
        byte_val    = 8'h00;
        take_hold   = 1'b0;
        send_bit    = 1'b0;
        bit_val     = 1'b0;
        count_ones  = 1'b0;
        go_eop      = 1'b0;

        wrap = (cnt_q == CNT_MAX);
        if (state_q != S_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    state_d     = S_SYNC;
                    cnt_d       = '0;
                    active_d    = 1'b1;
                    line_d      = SYM_K;   // SYNC bit 0 is a 0: J toggles to K
                    shift_d     = SYNC_REST;
                    bits_left_d = 3'd7;
                    ones_d      = 3'd0;
                    cur_last_d  = 1'b0;
`ifdef USB_TX_CRC16_EN
                    crc_d       = 16'hFFFF;
                    crc_sel_d   = 2'd0;
`endif
                end
            end
            S_SYNC: begin
                if (wrap) begin
                    if (bits_left_q != 3'd0) begin
                        send_bit = 1'b1;
                        bit_val  = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bits_left_d = bits_left_q - 3'd1;
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (wrap) begin
                    if (ones_q == 3'd6) begin
                        // Stuffed zero: shift register holds still for this bit time.
                        line_d = ~line_q;
                        ones_d = 3'd0;
                    end else if (bits_left_q != 3'd0) begin
                        send_bit    = 1'b1;
                        count_ones  = 1'b1;
                        bit_val     = shift_q[0];
                        shift_d     = shift_q >> 1;
                        bits_left_d = bits_left_q - 3'd1;
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (wrap) begin
                    if (eop_cnt_q) begin
                        state_d = S_EOP_J;
                        line_d  = SYM_J;
                    end else begin
                        eop_cnt_d = 1'b1;
                    end
                end
            end
            S_EOP_J: begin
                if (wrap) begin
                    state_d  = S_IDLE;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Byte boundary: pick the next byte, or finish / abort the packet.
        if (boundary) begin
            if (cur_last_q) begin
`ifdef USB_TX_CRC16_EN
                if (crc_sel_q == 2'd0) begin
                    load_byte = 1'b1;
                    byte_val  = ~crc_q[7:0];
                    crc_sel_d = 2'd1;
                end else if (crc_sel_q == 2'd1) begin
                    load_byte = 1'b1;
                    byte_val  = ~crc_q[15:8];
                    crc_sel_d = 2'd2;
                end else begin
                    go_eop = 1'b1;
                end
`else
                go_eop = 1'b1;
`endif
            end else if (hold_full_q) begin
                load_byte  = 1'b1;
                byte_val   = hold_data_q;
                take_hold  = 1'b1;
                cur_last_d = hold_last_q;
`ifdef USB_TX_CRC16_EN
                crc_d      = crc16_byte(crc_q, hold_data_q);
`endif
            end else begin
                go_eop  = 1'b1;
                error_d = 1'b1;
            end
        end

        if (load_byte) begin
            state_d     = S_DATA;
            send_bit    = 1'b1;
            count_ones  = 1'b1;
            bit_val     = byte_val[0];
            shift_d     = {1'b0, byte_val[7:1]};
            bits_left_d = 3'd7;
        end

        // NRZI: a 0 toggles J<->K, a 1 holds the line.
        if (send_bit) begin
            line_d = bit_val ? line_q : ~line_q;
            if (count_ones) begin
                ones_d = bit_val ? ones_q + 3'd1 : 3'd0;
            end
        end

        if (go_eop) begin
            state_d   = S_EOP_SE0;
            line_d    = SYM_SE0;
            eop_cnt_d = 1'b0;
        end

        if (take_hold) begin
            hold_full_d = 1'b0;
        end
        if (tx_if.tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_if.tx_data;
            hold_last_d = tx_if.tx_last;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= 8'h00;
            hold_last_q <= 1'b0;
            shift_q     <= 8'h00;
            bits_left_q <= 3'd0;
            cur_last_q  <= 1'b0;
            ones_q      <= 3'd0;
            line_q      <= SYM_J;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            eop_cnt_q   <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_q       <= 16'hFFFF;
            crc_sel_q   <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            cur_last_q  <= cur_last_d;
            ones_q      <= ones_d;
            line_q      <= line_d;
            active_q    <= active_d;
            done_q      <= done_d;
            error_q     <= error_d;
            eop_cnt_q   <= eop_cnt_d;
`ifdef USB_TX_CRC16_EN
            crc_q       <= crc_d;
            crc_sel_q   <= crc_sel_d;
`endif
        end
    end

    assign tx_if.tx_ready = ~hold_full_q;
    assign d_plus         = line_q[1];
    assign d_minus        = line_q[0];
    assign tx_active      = active_q;
    assign tx_done        = done_q;
    assign tx_error       = error_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: line symbols, timing, stuffing, underrun, reset, byte decode.
// Latency: n/a (bench).
// Backpressure: producer waits on tx_ready with a cycle bound.
module tb_usb_tx_encoder;

    localparam int CPB = 8;

    logic clk;
    logic n_rst;
    logic d_plus, d_minus, tx_active, tx_done, tx_error;

    usb_tx_encoder_if tx_if ();

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_if     (tx_if),
        .d_plus    (d_plus),
        .d_minus   (d_minus),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int num_checks = 0;
    int num_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor, sampled on the falling edge.
    int         cyc = 0;
    logic [1:0] sym_q[$];
    int         mon_start, mon_done, mon_err;
    int         mon_starts = 0, mon_done_n = 0, mon_err_n = 0;
    int         mon_phase = 0, mon_glitch = 0, mon_illegal = 0;
    logic       mon_prev_active = 1'b0;
    logic [1:0] mon_prev_line = 2'b10;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!n_rst) begin
            mon_prev_active = 1'b0;
        end else begin
            if (tx_active && !mon_prev_active) begin
                mon_start = cyc;
                mon_starts++;
                mon_phase = 0;
            end
            if (tx_active) begin
                if ({d_plus, d_minus} != mon_prev_line && mon_phase != 0) mon_glitch++;
                if (mon_phase == CPB / 2) sym_q.push_back({d_plus, d_minus});
                mon_phase = (mon_phase == CPB - 1) ? 0 : mon_phase + 1;
            end
            if (tx_done) begin
                mon_done = cyc;
                mon_done_n++;
            end
            if (tx_error) begin
                mon_err = cyc;
                mon_err_n++;
            end
            if (d_plus && d_minus) mon_illegal++;
            mon_prev_active = tx_active;
        end
        mon_prev_line = {d_plus, d_minus};
    end

    function automatic logic [255:0] s2v(input string s, output int n);
        logic [255:0] v;
        v = '0;
        n = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "J")      begin v = {v[253:0], 2'b10}; n++; end
            else if (s[i] == "K") begin v = {v[253:0], 2'b01}; n++; end
            else if (s[i] == "0") begin v = {v[253:0], 2'b00}; n++; end
        end
        return v;
    endfunction

    function automatic logic [255:0] q2v();
        logic [255:0] v;
        v = '0;
        foreach (sym_q[i]) v = {v[253:0], sym_q[i]};
        return v;
    endfunction

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Undo NRZI and stuffing on the captured symbols; SYNC is skipped.
    task automatic decode(output logic [63:0] bytes, output int nbytes, output int frame_err);
        logic [1:0] prev;
        logic       b;
        int         ones, nb;
        prev = 2'b10; ones = 0; nb = 0; bytes = '0; frame_err = 0;
        for (int i = 0; i < sym_q.size(); i++) begin
            if (sym_q[i] == 2'b00) break;
            b = (sym_q[i] == prev);
            prev = sym_q[i];
            if (i < 8) continue;
            if (ones == 6) begin
                if (b) frame_err++;
                ones = 0;
            end else begin
                ones = b ? ones + 1 : 0;
                if (nb < 64) bytes[nb] = b;
                nb++;
            end
        end
        nbytes = nb / 8;
        if (nb % 8 != 0) frame_err++;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        tx_if.tx_data  = d;
        tx_if.tx_last  = l;
        tx_if.tx_valid = 1'b1;
        while (!tx_if.tx_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic clear_mon();
        sym_q.delete();
        mon_err_n = 0;
    endtask

    task automatic check_packet(input string tag, input string exp, input int exp_done, input int exp_err);
        int n, n_before, exp_n;
        logic [255:0] exp_v;
        n_before = mon_done_n;
        n = 0;
        while (mon_done_n == n_before && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #1;
        exp_v = s2v(exp, exp_n);
        check_eq($sformatf("%s_done_seen", tag), mon_done_n > n_before, 1);
        check_eq($sformatf("%s_syms", tag), q2v(), exp_v);
        check_eq($sformatf("%s_nsym", tag), sym_q.size(), exp_n);
        check_eq($sformatf("%s_done_lat", tag), mon_done - mon_start, exp_done);
        check_eq($sformatf("%s_err_n", tag), mon_err_n, exp_err);
    endtask

    initial begin
        logic [63:0] got_bytes, exp_bytes;
        int          nbytes, frame_err, starts_before, exp_nbytes;
        logic [15:0] crc;

        n_rst = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", {d_plus, d_minus, tx_if.tx_ready, tx_active, tx_done, tx_error}, 6'b101000);
        n_rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_eq("idle_after_reset", {d_plus, d_minus, tx_active, 32'(mon_starts)}, {3'b100, 32'd0});

        // Single zero byte.
        clear_mon();
        send_byte(8'h00, 1'b1);
        check_packet("byte00", "KJKJKJKK JKJKJKJK 00J", 152, 0);

        // All ones: six K, stuffed J, then two more ones.
        clear_mon();
        send_byte(8'hFF, 1'b1);
        check_packet("byteFF", "KJKJKJKK KKKKKKJJJ 00J", 160, 0);

        // Run of ones crossing a byte boundary.
        clear_mon();
        send_byte(8'hF0, 1'b0);
        check_eq("f0_ready_low", tx_if.tx_ready, 1'b0);
        send_byte(8'h03, 1'b1);
        check_eq("03_ready_low", tx_if.tx_ready, 1'b0);
        check_packet("f0_03", "KJKJKJKK JKJKKKKK KKJKJKJKJ 00J", 224, 0);
        check_eq("f0_03_ready_idle", tx_if.tx_ready, 1'b1);

        // Underrun after a non-final byte.
        clear_mon();
        send_byte(8'hA5, 1'b0);
        check_packet("underrun", "KJKJKJKK KJJKJJKK 00J", 152, 1);
        check_eq("underrun_err_lat", mon_err - mon_start, 128);

        // Four bytes through the decoder model.
        clear_mon();
        for (int i = 0; i < 4; i++) send_byte(8'(i), i == 3);
        begin
            int n;
            n = 0;
            while (tx_active || tx_if.tx_ready == 1'b0) begin
                if (n >= 4000) break;
                @(posedge clk); n++;
            end
            repeat (2) @(posedge clk);
            #1;
            check_eq("multi_timeout", n < 4000, 1);
        end
        decode(got_bytes, nbytes, frame_err);
        exp_bytes = 64'h0000_0000_0302_0100;
        exp_nbytes = 4;
`ifdef USB_TX_CRC16_EN
        crc = 16'hFFFF;
        for (int i = 0; i < 4; i++) crc = crc_model(crc, 8'(i));
        crc = ~crc;
        exp_bytes[47:32] = crc;
        exp_nbytes = 6;
        crc = 16'hFFFF;
        for (int i = 0; i < 6; i++) crc = crc_model(crc, got_bytes[8*i +: 8]);
        check_eq("crc_residual", crc, 16'hB001);
`else
        crc = 16'h0000;
`endif
        check_eq("multi_nbytes", nbytes, exp_nbytes);
        check_eq("multi_bytes", got_bytes, exp_bytes);
        check_eq("multi_frame_err", frame_err, 0);

        // Reset in the middle of the data field with a byte still held.
        clear_mon();
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("midrst_pre", {tx_active, tx_if.tx_ready}, 2'b10);
        starts_before = mon_starts;
        #2;
        n_rst = 1'b0;
        #1;
        check_eq("midrst_out", {d_plus, d_minus, tx_active, tx_if.tx_ready, tx_done, tx_error}, 6'b100100);
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_eq("midrst_idle", {d_plus, d_minus, tx_active, 32'(mon_starts - starts_before)}, {3'b100, 32'd0});

        check_eq("no_se1", mon_illegal, 0);
        check_eq("symbol_timing", mon_glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
